fp_square: RTL
==============

Name: fp_square

Overview:
- Sequential floating-point squaring unit (x^2), the inverse direction of the FPU's square-root datapath.
- Consumes the same unpacked operand format and start/ready handshake as the sqrt unit: mantissa with explicit hidden bit, biased exponent, sign, type and class flags.
- Produces an unpacked, normalised result.
- Used by the FPU to check sqrt results (sqrt(x)^2 against x) and as a standalone square op.

Parameters:
M_SIZE, 53, operand/result mantissa width including hidden bit
EXP_SIZE, 11, exponent width
DBL_BIAS, 1023, double exponent bias
SGL_BIAS, 127, single exponent bias

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_mantisa  input  M_SIZE  operand mantissa; double: hidden bit [52]; single: bits [23:0], hidden bit [23], upper bits ignored
in_exp  input  EXP_SIZE  biased exponent; single uses [7:0]
in_sign  input  1  operand sign
in_type  input  1  1=double, 0=single
in_flags  input  3  class: 3'b100 normal, 3'b010 infinity, 3'b001 NaN, 3'b000 zero
start  input  1  request; sampled only in IDLE
out_mantisa  output  M_SIZE  result mantissa, same layout as input per type
out_exp  output  EXP_SIZE  biased result exponent
out_sign  output  1  result sign (always 0)
out_flags  output  3  result class, same encoding as in_flags
ready  output  1  result valid

Behaviour:
- Reset: rst=1 at a posedge -> state IDLE; all outputs 0; ready 0. Reset mid-operation aborts; no result produced.
- States: IDLE, MUL, NORM, DONE.
- IDLE + start=1: latch all inputs, clear ready. This is the accept edge, k.
  - in_flags normal -> MUL, iteration counter N (53 double, 24 single).
  - Otherwise -> DONE directly. Zero -> flags 000, all zero. Inf -> flags 010, exp all ones (8 bits single), mantissa 0. NaN -> flags 001, mantissa = hidden bit plus MSB fraction bit set, exp all ones.
- MUL: shift-add, one multiplier bit per cycle, LSB first, into a 2*M_SIZE (106-bit) accumulator. N cycles, then NORM.
- NORM, one cycle:
  - Product in [1,4). If product bit 2N-1 is set: shift right 1, norm=1; else norm=0.
  - e2 = 2*exp - bias + norm, computed in 13-bit signed.
  - Apply rounding, then the range check:
    - e2 >= 2047 (double) / 255 (single) -> infinity result as above.
    - e2 <= 0 -> zero result, no subnormals.
    - Otherwise flags 100.
- DONE: ready=1 and outputs held stable until the next accepted start, then ready drops at that accept edge.
- Latency:
  - Normal double: ready rises at edge k+55.
  - Normal single: ready rises at edge k+26.
  - Specials: ready rises at edge k+1.
- start while in MUL or NORM is ignored; start held high over several cycles is accepted once.
- start=1 in DONE starts a new operation (DONE accepts like IDLE).
- Single results: out_mantisa[52:24]=0, out_exp[10:8]=0.

Optional Feature:
ROUND_NEAREST_EN
- Defined: round-to-nearest-even using guard bit plus sticky (OR of the remaining discarded bits). A mantissa carry-out renormalises (mantissa = hidden bit only, exp+1) before the range check.
- Undefined: truncate; guard and sticky are discarded.

Test Plan:
1. Double 1.5: mantissa 53'h18000000000000, exp 1023, flags 100, start held 2 cycles -> ready at k+55; out_mantisa 53'h12000000000000, out_exp 1024, out_flags 100, out_sign 0.
2. Single -3.0: in_sign 1, mantissa 24'hC00000, exp 128, type 0 -> ready at k+26; out_mantisa 24'h900000, out_exp 130, out_sign 0.
3. Single rounding: mantissa 24'hC00001, exp 128.
   - With ROUND_NEAREST_EN: out_mantisa 24'h900002.
   - Without: out_mantisa 24'h900001.
   - out_exp 130 in both.
4. Double overflow (exp 1600) -> out_flags 010, out_exp 11'h7FF, mantissa 0. Double underflow (exp 400) -> out_flags 000, all zero.
5. Specials: flags 001 -> out_flags 001, ready at k+1. Flags 000 -> zero result, ready at k+1.
6. rst pulsed at k+20 of a double op -> ready stays 0, outputs 0. A new start afterwards completes correctly. start pulses during MUL are ignored.

Source files
------------

// File: rtl/fp_square.sv
`default_nettype none
// ============================================================================
// fp_square : sequential shift-add floating-point squarer (unpacked operands)
// Optional ROUND_NEAREST_EN selects round-to-nearest-even instead of truncate.
// Revision  : 1.0
// ============================================================================
module fp_square #(
  parameter int M_SIZE   = 53,
  parameter int EXP_SIZE = 11,
  parameter int DBL_BIAS = 1023,
  parameter int SGL_BIAS = 127
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [M_SIZE-1:0]   in_mantisa,
  input  logic [EXP_SIZE-1:0] in_exp,
  input  logic                in_sign,
  input  logic                in_type,
  input  logic [2:0]          in_flags,
  input  logic                start,
  output logic [M_SIZE-1:0]   out_mantisa,
  output logic [EXP_SIZE-1:0] out_exp,
  output logic                out_sign,
  output logic [2:0]          out_flags,
  output logic                ready
);

  localparam int         P_W      = 2 * M_SIZE;
  localparam int         S_M      = 24;
  localparam int         S_SHIFT  = P_W - 2 * S_M;
  localparam logic [2:0] C_NORMAL = 3'b100;
  localparam logic [2:0] C_INF    = 3'b010;
  localparam logic [2:0] C_NAN    = 3'b001;
  localparam logic [2:0] C_ZERO   = 3'b000;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_NORM = 2'd2, S_DONE = 2'd3} state_t;

  function automatic logic [EXP_SIZE-1:0] inf_exp(input logic dbl);
    return dbl ? {EXP_SIZE{1'b1}} : EXP_SIZE'(8'hFF);
  endfunction

  function automatic logic [M_SIZE-1:0] hidden_mant(input logic dbl);
    return dbl ? (M_SIZE'(1) << (M_SIZE - 1)) : M_SIZE'(24'h800000);
  endfunction

  state_t              state_q, state_d;
  logic                type_q, type_d;
  logic [EXP_SIZE-1:0] exp_q, exp_d;
  logic [P_W-1:0]      acc_q, acc_d;
  logic [P_W-1:0]      mcand_q, mcand_d;
  logic [M_SIZE-1:0]   mplier_q, mplier_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [M_SIZE-1:0]   omant_q, omant_d;
  logic [EXP_SIZE-1:0] oexp_q, oexp_d;
  logic [2:0]          oflags_q, oflags_d;
  logic                ready_q, ready_d;

  logic                  w_accept;
  logic [M_SIZE-1:0]     w_in_mant;
  logic                  w_norm;
  logic [P_W-1:0]        w_pd, w_pn;
  logic [M_SIZE-1:0]     w_mant_t, w_mant_f;
  logic signed [12:0]    w_e2, w_e2_f, w_e_max;

  assign w_accept  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign w_in_mant = in_type ? in_mantisa : {{(M_SIZE-S_M){1'b0}}, in_mantisa[S_M-1:0]};

  // Align the product so its leading one always sits at bit P_W-1
  assign w_norm   = type_q ? acc_q[P_W-1] : acc_q[2*S_M-1];
  assign w_pd     = type_q ? acc_q : (acc_q << S_SHIFT);
  assign w_pn     = w_norm ? w_pd : (w_pd << 1);
  assign w_mant_t = type_q ? w_pn[P_W-1 -: M_SIZE]
                           : {{(M_SIZE-S_M){1'b0}}, w_pn[P_W-1 -: S_M]};
  assign w_e2     = 13'({1'b0, exp_q, 1'b0})
                  - (type_q ? 13'(DBL_BIAS) : 13'(SGL_BIAS))
                  + {12'd0, w_norm};
  assign w_e_max  = type_q ? 13'sd2047 : 13'sd255;

`ifdef ROUND_NEAREST_EN
  logic              w_guard, w_sticky, w_rnd_up, w_carry;
  logic [M_SIZE:0]   w_mant_r;
  assign w_guard  = type_q ? w_pn[P_W-1-M_SIZE] : w_pn[P_W-1-S_M];
  assign w_sticky = type_q ? |w_pn[P_W-2-M_SIZE:0] : |w_pn[P_W-2-S_M:0];
  assign w_rnd_up = w_guard & (w_sticky | w_mant_t[0]);
  assign w_mant_r = {1'b0, w_mant_t} + {{M_SIZE{1'b0}}, w_rnd_up};
  assign w_carry  = type_q ? w_mant_r[M_SIZE] : w_mant_r[S_M];
  assign w_mant_f = w_carry ? hidden_mant(type_q) : w_mant_r[M_SIZE-1:0];
  assign w_e2_f   = w_e2 + {12'd0, w_carry};
`else
  assign w_mant_f = w_mant_t;
  assign w_e2_f   = w_e2;
`endif

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    omant_d  = omant_q;
    oexp_d   = oexp_q;
    oflags_d = oflags_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) ready_d = 1'b1;
        if (w_accept) begin
          ready_d  = 1'b0;
          type_d   = in_type;
          exp_d    = in_type ? in_exp : {{(EXP_SIZE-8){1'b0}}, in_exp[7:0]};
          acc_d    = '0;
          mcand_d  = {{M_SIZE{1'b0}}, w_in_mant};
          mplier_d = w_in_mant;
          cnt_d    = in_type ? 6'(M_SIZE) : 6'(S_M);
          state_d  = S_DONE;
          case (in_flags)
            C_NORMAL: state_d = S_MUL;
            C_INF: begin
              omant_d  = '0;
              oexp_d   = inf_exp(in_type);
              oflags_d = C_INF;
            end
            C_NAN: begin
              omant_d  = hidden_mant(in_type) | (hidden_mant(in_type) >> 1);
              oexp_d   = inf_exp(in_type);
              oflags_d = C_NAN;
            end
            default: begin
              omant_d  = '0;
              oexp_d   = '0;
              oflags_d = C_ZERO;
            end
          endcase
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_DONE;
        if (w_e2_f >= w_e_max) begin
          omant_d  = '0;
          oexp_d   = inf_exp(type_q);
          oflags_d = C_INF;
        end else if (w_e2_f <= 13'sd0) begin
          omant_d  = '0;
          oexp_d   = '0;
          oflags_d = C_ZERO;
        end else begin
          omant_d  = w_mant_f;
          oexp_d   = w_e2_f[EXP_SIZE-1:0];
          oflags_d = C_NORMAL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      type_q   <= 1'b0;
      exp_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      omant_q  <= '0;
      oexp_q   <= '0;
      oflags_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      exp_q    <= exp_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      omant_q  <= omant_d;
      oexp_q   <= oexp_d;
      oflags_q <= oflags_d;
      ready_q  <= ready_d;
    end
  end

  // The square of any real number is non-negative, so the operand sign is unused
  logic w_unused_sign;
  assign w_unused_sign = in_sign;

  assign out_mantisa = omant_q;
  assign out_exp     = oexp_q;
  assign out_sign    = 1'b0;
  assign out_flags   = oflags_q;
  assign ready       = ready_q;

endmodule
`default_nettype wire
